// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate truth-table checker: FSM states,
// widths, and a popcount helper used to score a sample.
package gate_chk_pkg;

  localparam int unsigned VEC_W     = 2;
  localparam int unsigned NUM_GATES = 5;
  localparam int unsigned ERR_W     = 8;
  localparam int unsigned ERR_MAX   = 255;
  localparam int unsigned MISM_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic [MISM_W-1:0] popcount5(input logic [NUM_GATES-1:0] bits);
    logic [MISM_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      cnt = cnt + MISM_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gate_truth_table_checker_expect.sv
// Combinational golden model of the gate block; output order is
// {and, or, not, xor, xnor}.
module gate_expect
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  assign expected = {a & b, a | b, ~a, a ^ b, ~(a ^ b)};

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sequential self-test of the two-input gate block: sweeps 00,01,10,11 LOOPS
// times, samples after a settle delay, and reports errors via start/done.
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             xor_in,
  input  logic             xnor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_vec,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_SAT     = ERR_W'(ERR_MAX);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [7:0]         loop_q, loop_d;
  logic [3:0]         settle_q, settle_d;
  logic [3:0]         fail_vec_q, fail_vec_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               pass_q, pass_d;

  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] observed;
  logic [MISM_W-1:0]    mism;
  logic [ERR_W:0]       err_sum;

  gate_expect u_expect (
    .a        (vec_q[1]),
    .b        (vec_q[0]),
    .expected (expected)
  );

  // The gate block is combinational, so its outputs are compared unregistered.
  assign observed = {and_in, or_in, not_in, xor_in, xnor_in};
  assign mism     = popcount5(expected ^ observed);
  assign err_sum  = {1'b0, err_count_q} + (ERR_W + 1)'(mism);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    loop_d      = loop_q;
    settle_d    = settle_q;
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          fail_vec_d  = '0;
          err_count_d = '0;
          pass_d      = 1'b0;
          vec_d       = '0;
          loop_d      = '0;
          state_d     = ST_APPLY;
        end
      end
      ST_APPLY: begin
        settle_d = SETTLE_INIT;
        state_d  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        err_count_d = (err_sum > {1'b0, ERR_SAT}) ? ERR_SAT : err_sum[ERR_W-1:0];
        if (mism != '0) fail_vec_d[vec_q] = 1'b1;
        if (vec_q == 2'd3 && loop_q == LOOP_LAST) begin
          // pass must already reflect this final sample when done is raised.
          pass_d  = (err_count_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          if (vec_q == 2'd3) loop_d = loop_q + 8'd1;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      loop_q      <= '0;
      settle_q    <= '0;
      fail_vec_q  <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      loop_q      <= loop_d;
      settle_q    <= settle_d;
      fail_vec_q  <= fail_vec_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  logic driving;
  assign driving   = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign a_out     = driving & vec_q[1];
  assign b_out     = driving & vec_q[0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail_vec  = fail_vec_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed self-checking bench: three checker instances (defaults, LOOPS=13,
// SETTLE_CYCLES=0) each wired to a behavioural gate block.
module tb_gate_truth_table_checker;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Default-parameter instance with a fault-selectable gate block.
  logic [1:0] fault_mode;  // 0 correct, 1 xor stuck 0, 2 all inverted
  logic start_m, a_m, b_m, busy_m, done_m, pass_m;
  logic and_m, or_m, not_m, xor_m, xnor_m, inv_m;
  logic [3:0] fail_m;
  logic [7:0] err_m;

  assign inv_m  = (fault_mode == 2'd2);
  assign and_m  = (a_m & b_m) ^ inv_m;
  assign or_m   = (a_m | b_m) ^ inv_m;
  assign not_m  = (~a_m) ^ inv_m;
  assign xor_m  = (fault_mode == 2'd1) ? 1'b0 : ((a_m ^ b_m) ^ inv_m);
  assign xnor_m = (~(a_m ^ b_m)) ^ inv_m;

  gate_truth_table_checker u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .a_out(a_m), .b_out(b_m),
    .and_in(and_m), .or_in(or_m), .not_in(not_m), .xor_in(xor_m), .xnor_in(xnor_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .fail_vec(fail_m), .err_count(err_m)
  );

  // LOOPS=13 instance against a fully inverted gate block.
  logic start_l, a_l, b_l, busy_l, done_l, pass_l;
  logic [3:0] fail_l;
  logic [7:0] err_l;

  gate_truth_table_checker #(.SETTLE_CYCLES(2), .LOOPS(13)) u_loop13 (
    .clk(clk), .rst_n(rst_n), .start(start_l), .a_out(a_l), .b_out(b_l),
    .and_in(~(a_l & b_l)), .or_in(~(a_l | b_l)), .not_in(a_l),
    .xor_in(~(a_l ^ b_l)), .xnor_in(a_l ^ b_l),
    .busy(busy_l), .done(done_l), .pass(pass_l), .fail_vec(fail_l), .err_count(err_l)
  );

  // SETTLE_CYCLES=0 instance against a correct gate block.
  logic start_s, a_s, b_s, busy_s, done_s, pass_s;
  logic [3:0] fail_s;
  logic [7:0] err_s;

  gate_truth_table_checker #(.SETTLE_CYCLES(0), .LOOPS(1)) u_settle0 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a_out(a_s), .b_out(b_s),
    .and_in(a_s & b_s), .or_in(a_s | b_s), .not_in(~a_s),
    .xor_in(a_s ^ b_s), .xnor_in(~(a_s ^ b_s)),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_vec(fail_s), .err_count(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_m;
      1:       return done_l;
      default: return done_s;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_m = v;
      1:       start_l = v;
      default: start_s = v;
    endcase
  endtask

  // Pulses start on the selected instance; returns the cycle done was seen
  // (start-accepting edge = cycle 0), or -1 if it never came.
  task automatic run_dut(input int sel, output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      if (done_of(sel) === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    obs = {a_m, b_m, busy_m, done_m, pass_m, fail_m, err_m};
    total++;
    if (obs !== 17'd0) begin
      bad++;
      $display("FAIL reset_main: got %h want 0", obs);
    end
    total++;
    if ({busy_l, done_l, pass_l, fail_l, err_l, busy_s, done_s, pass_s, fail_s, err_s} !== 30'd0) begin
      bad++;
      $display("FAIL reset_others: err_l=%0d err_s=%0d busy_l=%b busy_s=%b", err_l, err_s, busy_l, busy_s);
    end
  endtask

  task automatic test_defaults();
    int v;
    logic [1:0] exp_ab;
    fault_mode = 2'd0;
    @(negedge clk);
    start_m = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      start_m = 1'b0;
      v = (c - 1) / 4;
      exp_ab = (c <= 16) ? v[1:0] : 2'b00;
      total++;
      if ({a_m, b_m} !== exp_ab) begin
        bad++;
        $display("FAIL defaults_ab c=%0d: got %b want %b", c, {a_m, b_m}, exp_ab);
      end
      total++;
      if (done_m !== (c == 17)) begin
        bad++;
        $display("FAIL defaults_done c=%0d: got %b want %b", c, done_m, (c == 17));
      end
      total++;
      if (busy_m !== (c <= 17)) begin
        bad++;
        $display("FAIL defaults_busy c=%0d: got %b want %b", c, busy_m, (c <= 17));
      end
      if (c == 17 || c == 19) begin
        total++;
        if ({pass_m, fail_m, err_m} !== {1'b1, 4'b0000, 8'd0}) begin
          bad++;
          $display("FAIL defaults_result c=%0d: pass=%b fail_vec=%b err=%0d want 1/0000/0", c, pass_m, fail_m, err_m);
        end
      end
    end
  endtask

  task automatic test_xor_stuck();
    int dc;
    fault_mode = 2'd1;
    run_dut(0, dc);
    total++;
    if (dc !== 17) begin
      bad++;
      $display("FAIL xor_stuck_done: got cycle %0d want 17", dc);
    end
    total++;
    if ({pass_m, fail_m, err_m} !== {1'b0, 4'b0110, 8'd2}) begin
      bad++;
      $display("FAIL xor_stuck_result: pass=%b fail_vec=%b err=%0d want 0/0110/2", pass_m, fail_m, err_m);
    end
    fault_mode = 2'd0;
  endtask

  task automatic test_saturate();
    int dc;
    run_dut(1, dc);
    total++;
    if (dc !== 209) begin
      bad++;
      $display("FAIL saturate_done: got cycle %0d want 209", dc);
    end
    total++;
    if ({pass_l, fail_l, err_l} !== {1'b0, 4'b1111, 8'd255}) begin
      bad++;
      $display("FAIL saturate_result: pass=%b fail_vec=%b err=%0d want 0/1111/255", pass_l, fail_l, err_l);
    end
  endtask

  task automatic test_settle0();
    int v;
    logic [1:0] exp_ab;
    @(negedge clk);
    start_s = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_s = 1'b0;
      v = (c - 1) / 2;
      exp_ab = (c <= 8) ? v[1:0] : 2'b00;
      total++;
      if ({a_s, b_s} !== exp_ab) begin
        bad++;
        $display("FAIL settle0_ab c=%0d: got %b want %b", c, {a_s, b_s}, exp_ab);
      end
      total++;
      if (done_s !== (c == 9)) begin
        bad++;
        $display("FAIL settle0_done c=%0d: got %b want %b", c, done_s, (c == 9));
      end
      if (c == 9) begin
        total++;
        if ({pass_s, fail_s, err_s} !== {1'b1, 4'b0000, 8'd0}) begin
          bad++;
          $display("FAIL settle0_result: pass=%b fail_vec=%b err=%0d want 1/0000/0", pass_s, fail_s, err_s);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int done_n;
    int first;
    done_n = 0;
    first  = -1;
    fault_mode = 2'd0;
    @(negedge clk);
    start_m = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_m = (c == 5) || (c == 17);
      if (done_m === 1'b1) begin
        done_n++;
        if (first < 0) first = c;
      end
    end
    start_m = 1'b0;
    total++;
    if (done_n !== 1 || first !== 17) begin
      bad++;
      $display("FAIL start_ignored: done pulses=%0d first=%0d want 1 at 17", done_n, first);
    end
    total++;
    if ({busy_m, pass_m} !== 2'b01) begin
      bad++;
      $display("FAIL start_ignored_idle: busy=%b pass=%b want 0/1", busy_m, pass_m);
    end
  endtask

  task automatic test_start_held();
    int d1;
    int d2;
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    start_m = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 18 || c == 19) begin
        total++;
        if (busy_m !== (c == 19)) begin
          bad++;
          $display("FAIL held_gap c=%0d: busy=%b want %b", c, busy_m, (c == 19));
        end
      end
      if (done_m === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) begin
          d2 = c;
          start_m = 1'b0;
        end
      end
    end
    start_m = 1'b0;
    total++;
    if (d1 !== 17 || d2 !== 35) begin
      bad++;
      $display("FAIL held_spacing: done at %0d and %0d want 17 and 35", d1, d2);
    end
    total++;
    if (busy_m !== 1'b0) begin
      bad++;
      $display("FAIL held_stop: busy=%b want 0", busy_m);
    end
  endtask

  task automatic test_mid_run_reset();
    int dc;
    int done_seen;
    done_seen = 0;
    fault_mode = 2'd1;
    @(negedge clk);
    start_m = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_m = 1'b0;
    end
    total++;
    if ({busy_m, a_m, b_m, fail_m, err_m} !== {3'b110, 4'b0010, 8'd1}) begin
      bad++;
      $display("FAIL midreset_before: busy=%b ab=%b%b fail_vec=%b err=%0d want 1/10/0010/1", busy_m, a_m, b_m, fail_m, err_m);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_m, b_m, busy_m, done_m, pass_m, fail_m, err_m} !== 17'd0) begin
      bad++;
      $display("FAIL midreset_async: got %h want 0", {a_m, b_m, busy_m, done_m, pass_m, fail_m, err_m});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_m !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_m !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen !== 0 || busy_m !== 1'b0) begin
      bad++;
      $display("FAIL midreset_nodone: done seen %0d times busy=%b want 0/0", done_seen, busy_m);
    end
    fault_mode = 2'd0;
    run_dut(0, dc);
    total++;
    if (dc !== 17 || {pass_m, fail_m, err_m} !== {1'b1, 4'b0000, 8'd0}) begin
      bad++;
      $display("FAIL midreset_rerun: done=%0d pass=%b fail_vec=%b err=%0d want 17/1/0000/0", dc, pass_m, fail_m, err_m);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    fault_mode = 2'd0;
    start_m    = 1'b0;
    start_l    = 1'b0;
    start_s    = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_defaults();
    test_xor_stuck();
    test_saturate();
    test_settle0();
    test_start_ignored();
    test_start_held();
    test_mid_run_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
